fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control logic for a single-clock FIFO built around an external
// RAM with one-cycle read latency. It tracks the write/read pointers and
// entry count, raises registered status flags, and drives the memory
// strobes combinationally so that the RAM samples them on the same edge.
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   RESET_L       - synchronous active-low reset
//   push / pop    - write / read requests
//   data_in       - write data, passed straight through to mem_data
//   af_thresh     - almost-full level, latched in INIT
//   ae_thresh     - almost-empty level, latched in INIT
//   mem_write     - RAM write strobe
//   mem_read      - RAM read strobe
//   mem_addr_w    - RAM write address (write pointer)
//   mem_addr_r    - RAM read address (read pointer)
//   mem_data      - RAM write data
//   count         - registered entry count, 0..RAM_DEPTH
//   full, empty, almost_full, almost_empty - registered status flags
//   err           - sticky overflow/underflow indication
module fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr_w,
    output logic [ADDR_WIDTH-1:0] mem_addr_r,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  err
);

    typedef enum logic [1:0] {StInit, StActive, StError} state_e;

    localparam logic [ADDR_WIDTH-1:0] PtrOne  = 1;
    localparam logic [ADDR_WIDTH:0]   CntOne  = 1;
    localparam logic [ADDR_WIDTH:0]   CntFull = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   af_lvl_q, af_lvl_d;
    logic [ADDR_WIDTH:0]   ae_lvl_q, ae_lvl_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_flag_q, af_flag_d;
    logic                  ae_flag_q, ae_flag_d;
    logic                  wr_ok, rd_ok;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            state_q   <= StInit;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            af_lvl_q  <= '0;
            ae_lvl_q  <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_flag_q <= 1'b0;
            ae_flag_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            af_lvl_q  <= af_lvl_d;
            ae_lvl_q  <= ae_lvl_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_flag_q <= af_flag_d;
            ae_flag_q <= ae_flag_d;
        end
    end

    // Next-state logic. Error is sticky; only reset leaves it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   state_d = StActive;
            StActive: begin
                if ((push && full_q && !pop) || (pop && empty_q)) begin
                    state_d = StError;
                end
            end
            StError:  state_d = StError;
            default:  state_d = StInit;
        endcase
    end

    // Output logic: strobes are qualified by reset so the RAM is never
    // written while the controller is being reset.
    always_comb begin
        wr_ok      = RESET_L && (state_q != StInit) && push && (!full_q || pop);
        rd_ok      = RESET_L && (state_q != StInit) && pop && !empty_q;
        mem_write  = wr_ok;
        mem_read   = rd_ok;
        mem_addr_w = wr_ptr_q;
        mem_addr_r = rd_ptr_q;
        mem_data   = data_in;
        count      = count_q;
        full       = full_q;
        empty      = empty_q;
        almost_full  = af_flag_q;
        almost_empty = ae_flag_q;
        err        = (state_q == StError);
    end

    // Pointer/count update; flags are computed from the next count so they
    // are registered in step with it.
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CntOne;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CntOne;
        end
        // Thresholds are captured on the INIT edge and used for that edge's
        // flags too, so the first ACTIVE cycle already sees them.
        af_lvl_d  = (state_q == StInit) ? af_thresh : af_lvl_q;
        ae_lvl_d  = (state_q == StInit) ? ae_thresh : ae_lvl_q;
        full_d    = (count_d == CntFull);
        empty_d   = (count_d == '0);
        af_flag_d = (count_d >= af_lvl_d);
        ae_flag_d = (count_d <= ae_lvl_d);
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl. A queue-based reference model tracks the
// FIFO contents and status; a small RAM model with one-cycle read latency
// checks that data comes back in push order.
module tb_fifo_ctrl;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          RESET_L;
    logic          push, pop;
    logic [DW-1:0] data_in;
    logic [AW:0]   af_thresh, ae_thresh;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_addr_w, mem_addr_r;
    logic [DW-1:0] mem_data;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, err;

    fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .RESET_L     (RESET_L),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .af_thresh   (af_thresh),
        .ae_thresh   (ae_thresh),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_addr_w  (mem_addr_w),
        .mem_addr_r  (mem_addr_r),
        .mem_data    (mem_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .err         (err)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle registered read.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] rdata;
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr_w] <= mem_data;
        if (mem_read)  rdata <= ram[mem_addr_r];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = init, 1 = active, 2 = error.
    int            m_state = 0;
    logic [DW-1:0] m_q[$];
    int            m_wr = 0, m_rd = 0;
    int            m_af = 0, m_ae = 0;
    bit            e_full = 0, e_empty = 1, e_af = 0, e_ae = 1;

    task automatic step(input bit p, input bit o, input bit rst);
        logic [DW-1:0] d;
        logic [DW-1:0] popped;
        bit            act, ew, er, was_full, was_empty;
        d       = DW'($urandom);
        push    = p;
        pop     = o;
        data_in = d;
        RESET_L = !rst;
        #1;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        act = !rst && (m_state != 0);
        ew  = act && p && (!was_full || o);
        er  = act && o && !was_empty;
        check_eq("mem_write", mem_write, ew);
        check_eq("mem_read", mem_read, er);
        check_eq("mem_addr_w", mem_addr_w, m_wr);
        check_eq("mem_addr_r", mem_addr_r, m_rd);
        check_eq("mem_data", mem_data, d);
        @(posedge clk);
        #1;
        popped = '0;
        if (rst) begin
            m_state = 0;
            m_q.delete();
            m_wr = 0;
            m_rd = 0;
        end else if (m_state == 0) begin
            m_af    = int'(af_thresh);
            m_ae    = int'(ae_thresh);
            m_state = 1;
        end else begin
            if (er) begin
                popped = m_q.pop_front();
                m_rd   = (m_rd + 1) % DEPTH;
            end
            if (ew) begin
                m_q.push_back(d);
                m_wr = (m_wr + 1) % DEPTH;
            end
            if ((p && !o && was_full) || (o && was_empty)) m_state = 2;
        end
        if (rst) begin
            e_full = 0; e_empty = 1; e_af = 0; e_ae = 1;
        end else begin
            e_full  = (m_q.size() == DEPTH);
            e_empty = (m_q.size() == 0);
            e_af    = (m_q.size() >= m_af);
            e_ae    = (m_q.size() <= m_ae);
        end
        if (er) check_eq("rdata", rdata, popped);
        check_eq("count", count, m_q.size());
        check_eq("full", full, e_full);
        check_eq("empty", empty, e_empty);
        check_eq("almost_full", almost_full, e_af);
        check_eq("almost_empty", almost_empty, e_ae);
        check_eq("err", err, m_state == 2);
    endtask

    initial begin
        clk       = 0;
        RESET_L   = 0;
        push      = 0;
        pop       = 0;
        data_in   = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        @(posedge clk);
        #1;

        // Fill from reset, then simultaneous push/pop at full.
        step(0, 0, 1);
        step(0, 0, 0);
        repeat (8) step(1, 0, 0);
        step(1, 1, 0);
        // Overflow, error held, accept rules still apply in error.
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 1, 0);
        // Underflow from empty, then reset clears it.
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        // Interleaved pairs wrap both pointers.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0);
            step(0, 1, 0);
        end
        // Reset with entries queued, next push goes to address 0.
        repeat (5) step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);

        // Random traffic with occasional resets and new thresholds.
        for (int i = 0; i < 800; i++) begin
            bit r;
            r = ($urandom_range(0, 39) == 0);
            if (r) begin
                af_thresh = 4'($urandom_range(0, 8));
                ae_thresh = 4'($urandom_range(0, 8));
            end
            step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 45), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
